mdio_master: RTL and testbench

MDIO_MASTER -- requirements
Module: mdio_master

---
 rtl/mdio_master.sv | 250 +++++++++++++++++++++++++
 tb/tb_mdio_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_master
//  Description : Memory-mapped IEEE 802.3 clause-22 MDIO management master.
//                A CMD register write launches one read or write frame
//                (preamble, ST/op/phyad/regad, turnaround, 16 data bits, one
//                idle bit). The STATUS, CTRL and CLEAR registers report
//                completion, read data and errors.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CLK_DIV        MDC half-period in msoc_clk cycles (3..255)
//  Ports
//    msoc_clk       clock, all logic on rising edge
//    rst            asynchronous active-high reset
//    core_lsu_addr  word address, bits [3:2] select the register
//    core_lsu_wdata write data
//    we_d           write strobe, qualified by mdio_sel
//    mdio_sel       block select
//    mdio_rdata     combinational read data for core_lsu_addr
//    o_edutmdc      MDC
//    o_edutmdio     MDIO drive value
//    oe_edutmdio    MDIO output enable
//    i_edutmdio     MDIO pad input (asynchronous)
//    mdio_irq       completion interrupt, level (done & irq_en)
//  Build option
//    MDIO_PRE_SUPPRESS_EN  adds CTRL[1] pre_sup: skip the 32-bit preamble
// ============================================================================
module mdio_master #(
    parameter int CLK_DIV = 10
) (
    input  logic        msoc_clk,
    input  logic        rst,
    input  logic [3:0]  core_lsu_addr,
    input  logic [31:0] core_lsu_wdata,
    input  logic        we_d,
    input  logic        mdio_sel,
    output logic [31:0] mdio_rdata,
    output logic        o_edutmdc,
    output logic        o_edutmdio,
    output logic        oe_edutmdio,
    input  logic        i_edutmdio,
    output logic        mdio_irq
);

    localparam int               CNT_W        = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] C_HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] C_HALF_FIRST = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] C_BIT_LAST   = CNT_W'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_CMD  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [4:0]       r_bits, w_bits_nxt, w_bits_last;
    logic [31:0]      r_tx, w_tx_nxt;
    logic             r_rd, w_rd_nxt;
    logic             r_mdc, r_mdo, r_oe;
    logic             w_mdc_nxt, w_mdo_nxt, w_drive_nxt;
    logic             r_sync1, r_sync2;
    logic [15:0]      r_rdata;
    logic             r_done, r_rd_err, r_dropped, r_irq_en;
    logic             w_pre_sup;
    logic             w_wr, w_cmd_wr, w_legal, w_busy, w_accept, w_drop;
    logic             w_ctrl_wr, w_clear, w_bit_end, w_sample, w_fin_end;
    logic [1:0]       w_word, w_op;
    logic             w_unused_ok;

    assign w_unused_ok = ^{core_lsu_addr[1:0], core_lsu_wdata[31:28]};

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    assign w_wr      = mdio_sel & we_d;
    assign w_word    = core_lsu_addr[3:2];
    assign w_op      = core_lsu_wdata[27:26];
    assign w_legal   = (w_op == 2'b01) || (w_op == 2'b10);
    assign w_busy    = (r_state != S_IDLE);
    assign w_cmd_wr  = w_wr && (w_word == 2'd0) && w_legal;
    assign w_accept  = w_cmd_wr && !w_busy;
    assign w_drop    = w_cmd_wr && w_busy;
    assign w_ctrl_wr = w_wr && (w_word == 2'd2);
    assign w_clear   = w_wr && (w_word == 2'd3);

    // Bit timing: r_cnt runs 0..2*CLK_DIV-1 per bit; the first half is MDC low.
    assign w_bit_end = w_busy && (r_cnt == C_BIT_LAST);
    assign w_sample  = w_busy && r_rd && (r_cnt == C_HALF_LAST);
    assign w_fin_end = w_bit_end && (r_state == S_FIN);

`ifdef MDIO_PRE_SUPPRESS_EN
    logic r_pre_sup;
    always_ff @(posedge msoc_clk or posedge rst) begin
        if (rst) begin
            r_pre_sup <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_pre_sup <= core_lsu_wdata[1];
        end
    end
    assign w_pre_sup = r_pre_sup;
`else
    assign w_pre_sup = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Frame sequencer: next state and next pin values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_bits_nxt  = r_bits;
        case (r_state)
            S_PRE:   w_bits_last = 5'd31;
            S_CMD:   w_bits_last = 5'd13;
            S_TA:    w_bits_last = 5'd1;
            S_DATA:  w_bits_last = 5'd15;
            default: w_bits_last = 5'd0;
        endcase

        if (r_state == S_IDLE) begin
            w_bits_nxt = 5'd0;
            if (w_accept) begin
                w_state_nxt = w_pre_sup ? S_CMD : S_PRE;
            end
        end else if (w_bit_end) begin
            if (r_bits == w_bits_last) begin
                w_bits_nxt = 5'd0;
                case (r_state)
                    S_PRE:   w_state_nxt = S_CMD;
                    S_CMD:   w_state_nxt = S_TA;
                    S_TA:    w_state_nxt = S_DATA;
                    S_DATA:  w_state_nxt = S_FIN;
                    default: w_state_nxt = S_IDLE;
                endcase
            end else begin
                w_bits_nxt = r_bits + 5'd1;
            end
        end

        w_cnt_nxt = (!w_busy || w_bit_end) ? '0 : r_cnt + CNT_W'(1);
        w_rd_nxt  = w_accept ? (w_op == 2'b10) : r_rd;

        // r_tx holds ST, op, phyad, regad, TA(10), wdata; its MSB is the bit
        // currently on the wire once the preamble is over.
        w_tx_nxt = r_tx;
        if (w_accept) begin
            w_tx_nxt = {2'b01, core_lsu_wdata[27:16], 2'b10, core_lsu_wdata[15:0]};
        end else if (w_bit_end && (r_state == S_CMD || r_state == S_TA || r_state == S_DATA)) begin
            w_tx_nxt = {r_tx[30:0], 1'b0};
        end

        // Pins are registered from next-state values so they change exactly
        // on the first cycle of a bit (first cycle of the MDC-low half).
        w_drive_nxt = (w_state_nxt == S_PRE) || (w_state_nxt == S_CMD) ||
                      (!w_rd_nxt && (w_state_nxt == S_TA || w_state_nxt == S_DATA));
        w_mdo_nxt   = (w_state_nxt == S_PRE) ? 1'b1 : (w_drive_nxt & w_tx_nxt[31]);
        w_mdc_nxt   = (w_state_nxt != S_IDLE) && (w_cnt_nxt >= C_HALF_FIRST);
    end

    always_ff @(posedge msoc_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath, pins and status
    // ------------------------------------------------------------------
    always_ff @(posedge msoc_clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bits    <= 5'd0;
            r_tx      <= 32'd0;
            r_rd      <= 1'b0;
            r_mdc     <= 1'b0;
            r_mdo     <= 1'b0;
            r_oe      <= 1'b0;
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_rdata   <= 16'd0;
            r_done    <= 1'b0;
            r_rd_err  <= 1'b0;
            r_dropped <= 1'b0;
            r_irq_en  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_bits  <= w_bits_nxt;
            r_tx    <= w_tx_nxt;
            r_rd    <= w_rd_nxt;
            r_mdc   <= w_mdc_nxt;
            r_mdo   <= w_mdo_nxt;
            r_oe    <= w_drive_nxt;
            r_sync1 <= i_edutmdio;
            r_sync2 <= r_sync1;

            // A PHY answering drives 0 in the second turnaround bit.
            if (w_sample && (r_state == S_TA) && (r_bits == 5'd1)) begin
                r_rd_err <= r_sync2;
            end else if (w_accept) begin
                r_rd_err <= 1'b0;
            end

            if (w_sample && (r_state == S_DATA)) begin
                r_rdata <= {r_rdata[14:0], r_sync2};
            end

            // Completion wins over a simultaneous CLEAR.
            if (w_fin_end) begin
                r_done <= 1'b1;
            end else if (w_clear) begin
                r_done <= 1'b0;
            end

            if (w_accept) begin
                r_dropped <= 1'b0;
            end else if (w_drop) begin
                r_dropped <= 1'b1;
            end else if (w_clear) begin
                r_dropped <= 1'b0;
            end

            if (w_ctrl_wr) begin
                r_irq_en <= core_lsu_wdata[0];
            end
        end
    end

    always_comb begin
        mdio_rdata = 32'd0;
        case (w_word)
            2'd1:    mdio_rdata = {w_busy, r_done, r_rd_err, r_dropped, 12'd0, r_rdata};
            2'd2:    mdio_rdata = {30'd0, w_pre_sup, r_irq_en};
            default: mdio_rdata = 32'd0;
        endcase
    end

    assign o_edutmdc   = r_mdc;
    assign o_edutmdio  = r_mdo;
    assign oe_edutmdio = r_oe;
    assign mdio_irq    = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_mdio_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdio_master
//  Description : Self-checking bench for mdio_master. Expected MDIO frames are
//                built bit by bit from the clause-22 frame rules; a PHY model
//                answers read frames. Timing is derived from bit index and
//                CLK_DIV arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_master;

    localparam int CLK_DIV = 4;
    localparam int BIT_CYC = 2 * CLK_DIV;

    logic        msoc_clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  core_lsu_addr = 4'd0;
    logic [31:0] core_lsu_wdata = 32'd0;
    logic        we_d = 1'b0;
    logic        mdio_sel = 1'b0;
    logic [31:0] mdio_rdata;
    logic        o_edutmdc;
    logic        o_edutmdio;
    logic        oe_edutmdio;
    logic        i_edutmdio = 1'b1;
    logic        mdio_irq;

    int          n_assert = 0;
    int          n_fail   = 0;

    // reference model state
    logic [15:0] m_rdata  = 16'd0;
    logic        m_done   = 1'b0;
    logic        m_irq_en = 1'b0;
    logic [31:0] st;

    mdio_master #(.CLK_DIV(CLK_DIV)) dut (
        .msoc_clk       (msoc_clk),
        .rst            (rst),
        .core_lsu_addr  (core_lsu_addr),
        .core_lsu_wdata (core_lsu_wdata),
        .we_d           (we_d),
        .mdio_sel       (mdio_sel),
        .mdio_rdata     (mdio_rdata),
        .o_edutmdc      (o_edutmdc),
        .o_edutmdio     (o_edutmdio),
        .oe_edutmdio    (oe_edutmdio),
        .i_edutmdio     (i_edutmdio),
        .mdio_irq       (mdio_irq)
    );

    always #5 msoc_clk = ~msoc_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge msoc_clk);
        #1;
    endtask

    task automatic rd_reg(input logic [1:0] w, output logic [31:0] d);
        core_lsu_addr = {w, 2'b00};
        #1;
        d = mdio_rdata;
    endtask

    task automatic bus_write(input logic [1:0] w, input logic [31:0] d);
        core_lsu_addr  = {w, 2'b00};
        core_lsu_wdata = d;
        mdio_sel       = 1'b1;
        we_d           = 1'b1;
        tick();
        mdio_sel       = 1'b0;
        we_d           = 1'b0;
    endtask

    function automatic logic [31:0] pins();
        return {29'd0, o_edutmdc, o_edutmdio, oe_edutmdio};
    endfunction

    // One complete frame. data is the write payload or the PHY's read answer.
    // An optional bus write (inj_word/inj_data) is injected at frame cycle inj_at.
    task automatic run_frame(input string tag, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] regad, input logic [15:0] data, input bit phy_on,
                             input bit pre_sup, input int inj_at, input logic [1:0] inj_word,
                             input logic [31:0] inj_data);
        bit          q_mdo[$];
        bit          q_oe[$];
        bit          q_phy[$];
        logic [13:0] hdr;
        logic [31:0] s;
        bit          is_rd;
        bit          exp_err;
        bit          exp_drop;
        int          nbits;
        int          total;
        is_rd = (op == 2'b10);
        if (!pre_sup) begin
            for (int i = 0; i < 32; i++) begin
                q_mdo.push_back(1'b1); q_oe.push_back(1'b1); q_phy.push_back(1'b1);
            end
        end
        hdr = {2'b01, op, phy, regad};
        for (int i = 13; i >= 0; i--) begin
            q_mdo.push_back(hdr[i]); q_oe.push_back(1'b1); q_phy.push_back(1'b1);
        end
        if (is_rd) begin
            q_mdo.push_back(1'b0); q_oe.push_back(1'b0); q_phy.push_back(1'b1);
            q_mdo.push_back(1'b0); q_oe.push_back(1'b0); q_phy.push_back(!phy_on);
        end else begin
            q_mdo.push_back(1'b1); q_oe.push_back(1'b1); q_phy.push_back(1'b1);
            q_mdo.push_back(1'b0); q_oe.push_back(1'b1); q_phy.push_back(1'b1);
        end
        for (int i = 15; i >= 0; i--) begin
            q_mdo.push_back(is_rd ? 1'b0 : data[i]);
            q_oe.push_back(!is_rd);
            q_phy.push_back(phy_on ? data[i] : 1'b1);
        end
        q_mdo.push_back(1'b0); q_oe.push_back(1'b0); q_phy.push_back(1'b1);
        nbits = q_mdo.size();
        total = nbits * BIT_CYC;

        i_edutmdio = 1'b1;
        bus_write(2'd0, {4'd0, op, phy, regad, data});
        for (int c = 0; c < total; c++) begin
            int k;
            int ph;
            k  = c / BIT_CYC;
            ph = c % BIT_CYC;
            chk({tag, "_pins"}, pins(), {29'd0, (ph >= CLK_DIV), q_mdo[k], q_oe[k]});
            if (c == 0) begin
                rd_reg(2'd1, s);
                chk({tag, "_accept"}, s, {1'b1, m_done, 2'b00, 12'd0, m_rdata});
            end
            if (c == total - 1) begin
                rd_reg(2'd1, s);
                chk({tag, "_busy_last"}, {30'd0, s[31:30]}, {30'd0, 1'b1, m_done});
            end
            if (ph == CLK_DIV && k + 1 < nbits) i_edutmdio = q_phy[k + 1];
            if (c == inj_at) begin
                core_lsu_addr  = {inj_word, 2'b00};
                core_lsu_wdata = inj_data;
                mdio_sel       = 1'b1;
                we_d           = 1'b1;
            end else if (c == inj_at + 1) begin
                mdio_sel = 1'b0;
                we_d     = 1'b0;
            end
            tick();
        end
        mdio_sel = 1'b0;
        we_d     = 1'b0;

        exp_err  = is_rd && !phy_on;
        exp_drop = (inj_at >= 0) && (inj_word == 2'd0);
        if (is_rd) m_rdata = phy_on ? data : 16'hFFFF;
        m_done = 1'b1;
        rd_reg(2'd1, s);
        chk({tag, "_status"}, s, {1'b0, 1'b1, exp_err, exp_drop, 12'd0, m_rdata});
        chk({tag, "_irq"}, {31'd0, mdio_irq}, {31'd0, m_done & m_irq_en});
        chk({tag, "_idle_pins"}, pins(), 32'd0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_pins", pins(), 32'd0);
        chk("reset_irq", {31'd0, mdio_irq}, 32'd0);
        rd_reg(2'd1, st); chk("reset_status", st, 32'd0);
        rd_reg(2'd2, st); chk("reset_ctrl", st, 32'd0);
        rd_reg(2'd0, st); chk("cmd_reads_0", st, 32'd0);

        // ---------------- CTRL read/write ----------------
        bus_write(2'd2, 32'h0000_0003);
        rd_reg(2'd2, st);
`ifdef MDIO_PRE_SUPPRESS_EN
        chk("ctrl_rb", st, 32'h0000_0003);
`else
        chk("ctrl_rb", st, 32'h0000_0001);
`endif
        bus_write(2'd2, 32'h0000_0001);
        m_irq_en = 1'b1;
        bus_write(2'd3, 32'hFFFF_FFFF);
        rd_reg(2'd3, st); chk("clear_reads_0", st, 32'd0);

        // ---------------- illegal ops ignored ----------------
        bus_write(2'd0, {4'd0, 2'b00, 5'd1, 5'd0, 16'h1140});
        rd_reg(2'd1, st); chk("op00_ignored", st, 32'd0);
        chk("op00_pins", pins(), 32'd0);
        bus_write(2'd0, {4'd0, 2'b11, 5'd1, 5'd0, 16'h1140});
        rd_reg(2'd1, st); chk("op11_ignored", st, 32'd0);
        chk("op11_pins", pins(), 32'd0);

        // ---------------- directed frames ----------------
        run_frame("wr_1140", 2'b01, 5'd1, 5'd0, 16'h1140, 1'b1, 1'b0, -1, 2'd0, 32'd0);
        chk("irq_set", {31'd0, mdio_irq}, 32'd1);
        bus_write(2'd3, 32'd0);
        m_done = 1'b0;
        chk("irq_cleared", {31'd0, mdio_irq}, 32'd0);
        rd_reg(2'd1, st); chk("clear_status", st, {16'd0, m_rdata});

        run_frame("rd_796d", 2'b10, 5'd1, 5'd2, 16'h796D, 1'b1, 1'b0, -1, 2'd0, 32'd0);

        bus_write(2'd3, 32'd0);
        m_done = 1'b0;
        // CLEAR lands in the same cycle as completion: done must still set.
        run_frame("rd_nophy", 2'b10, 5'd1, 5'd2, 16'h0000, 1'b0, 1'b0,
                  65 * BIT_CYC - 1, 2'd3, 32'd0);

        run_frame("wr_drop", 2'b01, 5'd3, 5'd9, 16'hBEEF, 1'b1, 1'b0,
                  100, 2'd0, {4'd0, 2'b10, 5'd31, 5'd31, 16'hA5A5});
        bus_write(2'd3, 32'd0);
        m_done = 1'b0;
        rd_reg(2'd1, st); chk("clear_dropped", st, {16'd0, m_rdata});

        // ---------------- randomized frames ----------------
        for (int n = 0; n < 3; n++) begin
            logic [1:0]  r_op;
            logic [4:0]  r_phy;
            logic [4:0]  r_reg;
            logic [15:0] r_dat;
            bit          r_on;
            r_op  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            r_phy = 5'($urandom);
            r_reg = 5'($urandom);
            r_dat = 16'($urandom);
            r_on  = ($urandom_range(0, 3) != 0);
            run_frame("rand", r_op, r_phy, r_reg, r_dat, r_on, 1'b0, -1, 2'd0, 32'd0);
        end

`ifdef MDIO_PRE_SUPPRESS_EN
        bus_write(2'd2, 32'h0000_0003);
        run_frame("presup_wr", 2'b01, 5'd1, 5'd0, 16'h1140, 1'b1, 1'b1, -1, 2'd0, 32'd0);
        bus_write(2'd2, 32'h0000_0001);
`endif

        // ---------------- reset mid-DATA ----------------
        bus_write(2'd0, {4'd0, 2'b01, 5'd2, 5'd4, 16'hFFFF});
        repeat (53 * BIT_CYC + CLK_DIV + 1) tick();
        chk("abort_pre_pins", pins(), 32'd7);
        chk("abort_pre_irq", {31'd0, mdio_irq}, {31'd0, m_done & m_irq_en});
        rst = 1'b1;
        #1;
        chk("abort_pins", pins(), 32'd0);
        chk("abort_irq", {31'd0, mdio_irq}, 32'd0);
        rd_reg(2'd1, st); chk("abort_status", st, 32'd0);
        rd_reg(2'd2, st); chk("abort_ctrl", st, 32'd0);
        tick();
        rst = 1'b0;
        m_done = 1'b0; m_irq_en = 1'b0; m_rdata = 16'd0;
        repeat (2 * BIT_CYC) tick();
        chk("post_abort_pins", pins(), 32'd0);
        rd_reg(2'd1, st); chk("post_abort_status", st, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
